// File: rtl/acc_mem_pkg.sv
// rtl/acc_mem_pkg.sv - shared types and limits for the data RAM arbiter
package acc_mem_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_HOST, OWN_ACC} owner_e;
  typedef enum logic [1:0] {ARB, LOCK, YIELD} arb_state_e;

  localparam int RD_LAT_MIN    = 1;
  localparam int RD_LAT_MAX    = 4;
  localparam int MAX_BURST_MIN = 2;
  localparam int MAX_BURST_MAX = 255;

endpackage

// File: rtl/acc_rd_tag_pipe.sv
// rtl/acc_rd_tag_pipe.sv - read-owner tag delay line aligned to RAM read latency
module acc_rd_tag_pipe
  import acc_mem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clk,
  input  logic   reset_n,
  input  owner_e tag_in,
  output logic   disp_rvalid,
  output logic   host_rvalid,
  output logic   acc_rvalid
);

  owner_e pipe [RD_LAT];

  // Clearing on reset drops in-flight tags so pre-reset reads never return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= OWN_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign disp_rvalid = (pipe[RD_LAT-1] == OWN_DISP);
  assign host_rvalid = (pipe[RD_LAT-1] == OWN_HOST);
  assign acc_rvalid  = (pipe[RD_LAT-1] == OWN_ACC);

endmodule

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - single-port data RAM arbiter: display first, host/acc round-robin with acc burst lock
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  input  logic              acc_lock,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  arb_state_e        state, state_nxt;
  logic              rr_acc, rr_acc_nxt;
  logic [7:0]        burst_cnt, burst_cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              host_g, acc_g;
  owner_e            tag_in;

  always_comb begin
    host_g        = 1'b0;
    acc_g         = 1'b0;
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    rr_acc_nxt    = rr_acc;
    if (!disp_req) begin
      case (state)
        ARB: begin
          if (host_req && acc_req) begin
            acc_g  = rr_acc;
            host_g = !rr_acc;
          end else begin
            host_g = host_req;
            acc_g  = acc_req;
          end
        end
        LOCK:    if (acc_req) acc_g = 1'b1; else host_g = host_req;
        YIELD:   host_g = host_req;
        default: ;
      endcase
    end
    case (state)
      ARB: begin
        if (acc_g && acc_lock) begin
          state_nxt     = LOCK;
          burst_cnt_nxt = 8'd1;
        end
      end
      LOCK: begin
        if (!acc_lock || !acc_req) begin
          state_nxt     = ARB;
          burst_cnt_nxt = 8'd0;
        end else begin
          if (acc_g && burst_cnt != MAX_CNT) burst_cnt_nxt = burst_cnt + 8'd1;
          // Yield right after the grant that fills the burst, so host gets the very next slot.
          if (burst_cnt_nxt == MAX_CNT && host_req) state_nxt = YIELD;
        end
      end
      YIELD: begin
        if (host_g) begin
          state_nxt     = (acc_lock && acc_req) ? LOCK : ARB;
          burst_cnt_nxt = 8'd0;
        end else if (!host_req) begin
          state_nxt = LOCK;
        end
      end
      default: state_nxt = ARB;
    endcase
    if (host_g) rr_acc_nxt = 1'b1;
    if (acc_g)  rr_acc_nxt = 1'b0;
  end

  assign disp_gnt = reset_n & disp_req;
  assign host_gnt = reset_n & host_g;
  assign acc_gnt  = reset_n & acc_g;

  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    tag_in    = OWN_NONE;
    if (disp_gnt) begin
      mem_addr = disp_addr;
      tag_in   = OWN_DISP;
    end else if (host_gnt) begin
      mem_addr  = host_addr;
      mem_we    = host_we;
      mem_wdata = host_wdata;
      tag_in    = host_we ? OWN_NONE : OWN_HOST;
    end else if (acc_gnt) begin
      mem_addr  = acc_addr;
      mem_we    = acc_we;
      mem_wdata = acc_wdata;
      tag_in    = acc_we ? OWN_NONE : OWN_ACC;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB;
      rr_acc    <= 1'b0;
      burst_cnt <= 8'd0;
      addr_q    <= '0;
    end else begin
      state     <= state_nxt;
      rr_acc    <= rr_acc_nxt;
      burst_cnt <= burst_cnt_nxt;
      addr_q    <= mem_addr;
    end
  end

  acc_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .tag_in      (tag_in),
    .disp_rvalid (disp_rvalid),
    .host_rvalid (host_rvalid),
    .acc_rvalid  (acc_rvalid)
  );

  assign rdata = mem_rdata;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// tb/tb_acc_mem_arbiter.sv - scoreboard bench for acc_mem_arbiter
module tb_acc_mem_arbiter;
  import acc_mem_pkg::*;

  localparam int ADDR_W = 16, DATA_W = 32, RD_LAT = 1, MAX_BURST = 4;

  logic clk = 1'b0, reset_n = 1'b0;
  logic disp_req = 0, host_req = 0, host_we = 0, acc_req = 0, acc_we = 0, acc_lock = 0;
  logic [ADDR_W-1:0] disp_addr = '0, host_addr = '0, acc_addr = '0, mem_addr;
  logic [DATA_W-1:0] host_wdata = '0, acc_wdata = '0, rdata, mem_wdata, mem_rdata = '0;
  logic disp_gnt, host_gnt, acc_gnt, disp_rvalid, host_rvalid, acc_rvalid, mem_we;

  always #10 clk = ~clk;

  acc_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_lock(acc_lock), .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM model: unwritten words read as {A5C3, addr}; delta holds the XOR of written data.
  bit [31:0] delta [0:1023];
  function automatic logic [31:0] ram_val(input logic [15:0] a);
    return {16'hA5C3, a} ^ delta[a[9:0]];
  endfunction
  always @(posedge clk) begin
    if (mem_we) delta[mem_addr[9:0]] <= mem_wdata ^ {16'hA5C3, mem_addr};
    mem_rdata <= ram_val(mem_addr);
  end

  typedef struct { owner_e own; logic [31:0] data; int due; } exp_t;
  exp_t sb[$];
  int tests = 0, failed = 0, cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (disp_rvalid || host_rvalid || acc_rvalid) begin
        owner_e got;
        got = disp_rvalid ? OWN_DISP : host_rvalid ? OWN_HOST : OWN_ACC;
        tests++;
        if ((32'(disp_rvalid) + 32'(host_rvalid) + 32'(acc_rvalid)) != 1 || sb.size() == 0) begin
          failed++;
          $display("FAIL sb_unexpected_rvalid: rvalid d/h/a=%b%b%b required none", disp_rvalid, host_rvalid, acc_rvalid);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (got !== e.own || rdata !== e.data || cyc != e.due) begin
            failed++;
            $display("FAIL sb_read: owner=%0d data=%h cyc=%0d required owner=%0d data=%h cyc=%0d",
                     got, rdata, cyc, e.own, e.data, e.due);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        tests++;
        failed++;
        $display("FAIL sb_missing_rvalid: none at cyc=%0d required owner=%0d", cyc, sb[0].own);
        void'(sb.pop_front());
      end
      if (disp_gnt)                 sb.push_back('{OWN_DISP, ram_val(disp_addr), cyc + RD_LAT});
      else if (host_gnt && !host_we) sb.push_back('{OWN_HOST, ram_val(host_addr), cyc + RD_LAT});
      else if (acc_gnt && !acc_we)   sb.push_back('{OWN_ACC,  ram_val(acc_addr),  cyc + RD_LAT});
    end
  end

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      disp_req = 0; host_req = 0; acc_req = 0; acc_lock = 0; host_we = 0; acc_we = 0;
    end
  endtask

  task automatic test_reset;
    reset_n = 0; disp_req = 1; host_req = 1; acc_req = 1; host_we = 1; acc_we = 1; acc_lock = 1;
    disp_addr = 16'h0077; host_addr = 16'h0011; acc_addr = 16'h0022;
    host_wdata = 32'h1234_5678; acc_wdata = 32'h8765_4321;
    repeat (2) @(negedge clk);
    tests++; if ({disp_gnt, host_gnt, acc_gnt, disp_rvalid, host_rvalid, acc_rvalid} !== 6'b0) begin
      failed++; $display("FAIL reset_gnt_rvalid: got %b required 000000",
                         {disp_gnt, host_gnt, acc_gnt, disp_rvalid, host_rvalid, acc_rvalid}); end
    tests++; if (mem_we !== 1'b0) begin failed++; $display("FAIL reset_mem_we: got %b required 0", mem_we); end
    tests++; if (mem_addr !== 16'h0) begin failed++; $display("FAIL reset_mem_addr: got %h required 0000", mem_addr); end
    tests++; if (mem_wdata !== 32'h0) begin failed++; $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
    @(posedge clk); #1; reset_n = 1;
    @(negedge clk);
    tests++; if ({disp_gnt, host_gnt, acc_gnt} !== 3'b100) begin
      failed++; $display("FAIL reset_first_gnt: got %b required 100", {disp_gnt, host_gnt, acc_gnt}); end
    drive_idle(2);
  endtask

  task automatic test_disp_priority;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      disp_req = 1; disp_addr = 16'h0100 + 16'(i);
      host_req = 1; host_we = 0; host_addr = 16'h0010;
      acc_req = 1; acc_we = 0; acc_addr = 16'h0020; acc_lock = 0;
      @(negedge clk);
      tests++; if ({disp_gnt, host_gnt, acc_gnt} !== 3'b100 || mem_addr !== 16'h0100 + 16'(i)) begin
        failed++; $display("FAIL disp_priority[%0d]: gnt=%b addr=%h required 100 addr=%h",
                           i, {disp_gnt, host_gnt, acc_gnt}, mem_addr, 16'h0100 + 16'(i)); end
      if (i == 1) begin
        tests++; if (disp_rvalid !== 1'b1 || rdata !== 32'hA5C3_0100) begin
          failed++; $display("FAIL disp_rdata_0100: rvalid=%b rdata=%h required 1 a5c30100", disp_rvalid, rdata); end
      end
    end
    drive_idle(2);
  endtask

  task automatic test_round_robin;
    @(posedge clk); #1;
    host_req = 1; host_we = 0; host_addr = 16'h0010;
    acc_req = 1; acc_we = 0; acc_addr = 16'h0020; acc_lock = 0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] exp_g;
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b001;
      @(negedge clk);
      tests++; if ({disp_gnt, host_gnt, acc_gnt} !== exp_g) begin
        failed++; $display("FAIL round_robin[%0d]: gnt=%b required %b", i, {disp_gnt, host_gnt, acc_gnt}, exp_g); end
      if (i == 1) begin
        tests++; if (host_rvalid !== 1'b1 || rdata !== 32'hA5C3_0010) begin
          failed++; $display("FAIL rr_host_rdata: rvalid=%b rdata=%h required 1 a5c30010", host_rvalid, rdata); end
      end
    end
    drive_idle(2);
  endtask

  // One host write first so the round-robin pointer favours the accelerator.
  task automatic run_lock(input int disp_period, input string name);
    logic [9:0] got;
    int n;
    got = '0; n = 0;
    @(posedge clk); #1; host_req = 1; host_we = 1; host_addr = 16'h0030; host_wdata = 32'h0000_1111;
    @(negedge clk);
    tests++; if (host_gnt !== 1'b1) begin failed++; $display("FAIL %s_prelude: host_gnt=%b required 1", name, host_gnt); end
    @(posedge clk); #1;
    host_we = 0; host_addr = 16'h0031; acc_req = 1; acc_lock = 1; acc_we = 0; acc_addr = 16'h0040;
    for (int c = 0; c < 40 && n < 10; c++) begin
      disp_req = (disp_period > 0) && (c % disp_period == disp_period - 1);
      disp_addr = 16'h0200 + 16'(c);
      @(negedge clk);
      tests++; if (disp_gnt !== disp_req || (host_gnt && acc_gnt) || (disp_gnt && (host_gnt || acc_gnt))) begin
        failed++; $display("FAIL %s_slot[%0d]: gnt=%b disp_req=%b", name, c, {disp_gnt, host_gnt, acc_gnt}, disp_req); end
      if (host_gnt && n < 10) begin got[n] = 1'b1; n++; end
      else if (acc_gnt && n < 10) begin got[n] = 1'b0; n++; end
      @(posedge clk); #1;
    end
    disp_req = 0; host_req = 0; acc_req = 0; acc_lock = 0;
    tests++; if (n != 10 || got !== 10'b10_0001_0000) begin
      failed++; $display("FAIL %s_sequence: grants=%0d pattern=%b required 10 pattern=1000010000", name, n, got); end
    drive_idle(2);
  endtask

  task automatic test_write_readback;
    bit seen;
    @(posedge clk); #1; acc_req = 1; acc_we = 1; acc_addr = 16'h0042; acc_wdata = 32'hDEAD_BEEF;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); if (acc_gnt) seen = 1; end
    tests++; if (!seen || mem_we !== 1'b1) begin failed++; $display("FAIL wr_acc_gnt: seen=%0d we=%b required 1 1", seen, mem_we); end
    @(posedge clk); #1; acc_req = 0; acc_we = 0; host_req = 1; host_we = 0; host_addr = 16'h0042;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); if (host_gnt) seen = 1; end
    @(posedge clk); #1; host_req = 0;
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      if (k > 0) @(negedge clk); else @(negedge clk);
      if (host_rvalid) seen = 1;
    end
    tests++; if (!seen || rdata !== 32'hDEAD_BEEF) begin
      failed++; $display("FAIL readback_0042: rvalid_seen=%0d rdata=%h required 1 deadbeef", seen, rdata); end
    drive_idle(2);
  endtask

  task automatic test_reset_mid_read;
    bit seen, bad;
    @(posedge clk); #1; host_req = 1; host_we = 0; host_addr = 16'h0055;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin @(negedge clk); if (host_gnt) seen = 1; end
    tests++; if (!seen) begin failed++; $display("FAIL midreset_gnt: host_gnt never seen required 1"); end
    #1; reset_n = 0; host_req = 0;
    bad = 0;
    repeat (2) @(posedge clk);
    #1; reset_n = 1;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (host_rvalid) bad = 1; end
    tests++; if (bad) begin failed++; $display("FAIL midreset_rvalid: host_rvalid=1 after reset required 0"); end
  endtask

  initial begin
    test_reset();
    test_disp_priority();
    test_round_robin();
    run_lock(0, "burst_lock");
    run_lock(3, "lock_disp");
    test_write_readback();
    test_reset_mid_read();
    drive_idle(3);
    tests++; if (sb.size() != 0) begin failed++; $display("FAIL sb_drain: %0d pending required 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/acc_mem_arbiter.md
Name: acc_mem_arbiter

Overview:
- Arbitrates the single-port on-chip data RAM among three requesters: display line prefetch (feeds the VGA scanout), host bus (Avalon-slave register path), and the accelerator datapath.
- Issues at most one RAM access per clk.
- Display is fixed highest priority. Host and accelerator share the remaining slots round-robin, with an accelerator burst lock capped by MAX_BURST.
- Returns read data to the owning requester after the RAM read latency.

Parameters:
ADDR_W, 16, RAM word-address width
DATA_W, 32, RAM data width
RD_LAT, 1, cycles from granted read address to valid mem_rdata (1..4)
MAX_BURST, 16, max consecutive accelerator grants under lock while host is waiting (2..255)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
disp_req  in  1  display read request
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display access accepted this cycle
disp_rvalid  out  1  rdata belongs to display
host_req  in  1  host request
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  host access accepted
host_rvalid  out  1  rdata belongs to host
acc_req  in  1  accelerator request
acc_we  in  1  accelerator write enable
acc_addr  in  ADDR_W  accelerator address
acc_wdata  in  DATA_W  accelerator write data
acc_lock  in  1  accelerator requests burst ownership
acc_gnt  out  1  accelerator access accepted
acc_rvalid  out  1  rdata belongs to accelerator
rdata  out  DATA_W  read data, shared by all requesters
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset:
  - Reset is asynchronous; all registers clear on reset_n low.
  - All gnt and rvalid outputs are 0; mem_we=0, mem_addr=0, mem_wdata=0.
  - RR pointer favours host; burst_cnt=0; state ARB.
- Handshake:
  - Requester holds req, addr, we and wdata stable until it sees gnt.
  - gnt is combinational from current req and registered state. One gnt per cycle, at most one owner.
  - mem_addr, mem_we and mem_wdata are a combinational mux of the granted requester. When nothing is granted, mem_we=0 and mem_addr holds its last value through a registered copy.
- Read return:
  - A granted read (we=0) pushes the owner tag into an RD_LAT-deep pipe.
  - The matching *_rvalid pulses exactly RD_LAT cycles after gnt.
  - rdata = mem_rdata passthrough.
  - Writes push the tag NONE and produce no rvalid.
- Priority:
  1. disp_req always wins, including during an accelerator lock.
  2. Otherwise, in ARB, host vs acc alternate by RR pointer. The pointer flips to the other requester after each host/acc grant. A sole requester is always granted.
- State machine (arb_state_e):
  - ARB -> LOCK when acc_gnt is issued with acc_lock=1. burst_cnt <- 1.
  - LOCK: acc is granted in every non-display slot while acc_req=1, regardless of the RR pointer. burst_cnt increments only on acc grants and saturates at MAX_BURST.
  - LOCK -> ARB when acc_lock=0 or acc_req=0 at a cycle edge. burst_cnt <- 0.
  - LOCK -> YIELD when burst_cnt==MAX_BURST and host_req=1.
  - YIELD: the next non-display slot goes to host if host_req=1. Then -> LOCK with burst_cnt <- 0 if acc_lock still 1, else -> ARB. If host_req drops in YIELD, return to LOCK with no host grant.
  - At MAX_BURST with host_req=0, acc keeps being granted and burst_cnt stays at MAX_BURST.
- Simultaneous events:
  - All three requesting: disp is granted; host/acc are resolved by pointer or lock next cycle.
  - acc_lock=1 with acc_req=0 has no effect.
- Reset mid-operation: in-flight read tags are discarded, so no rvalid is emitted after reset_n deasserts for reads issued before reset.
- Display is never stalled. disp_gnt == disp_req in every cycle.

Decomposition:
- Package acc_mem_pkg:
  - owner_e {OWN_NONE, OWN_DISP, OWN_HOST, OWN_ACC}
  - arb_state_e {ARB, LOCK, YIELD}
  - localparam limits for RD_LAT and MAX_BURST
- Sub-module acc_rd_tag_pipe:
  - RD_LAT-stage shift register of owner_e with async active-low clear.
  - Decodes the three rvalid outputs.

Test Plan:
- Reset: hold reset_n=0 with all req=1 -> all gnt=0, rvalid=0, mem_we=0. Release -> first cycle grants disp.
- Display priority: disp_req=host_req=acc_req=1 for 4 cycles, disp_addr=0x0100..0x0103 -> disp_gnt every cycle, host_gnt=acc_gnt=0. rdata of 0x0100 arrives with disp_rvalid one cycle after its gnt (RD_LAT=1).
- Round-robin: host and acc requesting continuously, no disp, no lock -> grants alternate host, acc, host, acc; host reads 0x0010 -> host_rvalid with that word one cycle later.
- Burst lock: MAX_BURST=4, acc_lock=1, acc_req=1, host_req=1 from cycle 0 -> grant sequence acc×4, host×1, acc×4, host×1.
- Lock with display: same as the burst-lock case but with disp_req pulsed every 3rd cycle -> disp granted on those cycles and burst_cnt unaffected, so acc still gets exactly 4 grants before the host slot.
- Write/read-back and reset mid-read: acc writes 0xDEADBEEF to 0x0042, then host reads 0x0042 -> host_rvalid with 0xDEADBEEF. Assert reset_n=0 the cycle after a host read gnt -> no host_rvalid appears.
